ssd_scan_ctrl: RTL and testbench

Time-multiplexed driver for the 4-digit seven-segment display.
- Generates the digit select pair S1/S0 that steers the 4:1 nibble multiplexer.
- Receives the selected nibble back as W/X/Y/Z, decodes it to active-low segments and drives the active-low digit anodes.
- Inserts a dead (ghost-suppression) interval between digits and suppresses leading zeros.
- Sits between the per-digit hex sources/mux and the board display pins.

---
 rtl/ssd_pkg.sv | 30 +++
 rtl/ssd_hex_decode.sv | 19 +
 rtl/ssd_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: scan FSM state enum, all-dark anode/segment codes, the 16-entry
// hex-to-segment table (gfedcba, active-low) and a small integer max helper.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Index 0 is the rightmost 7-bit slice: entry n is the pattern for hex n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Hex nibble to active-low seven-segment pattern (gfedcba, seg[0] = a).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
//
// Ports:
//   nib - hex digit to display
//   seg - active-low segment pattern from the package table
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with dead-time and leading-zero blanking.
// Latency: nibble sampled on the last DEAD cycle, shown from the next cycle for REFRESH_DIV cycles.
// Backpressure: none; Enable low darkens the display on the next cycle and restarts at digit 3.
//
// Ports:
//   Clock, Resetn     - rising-edge clock, synchronous active-low reset
//   Enable            - 1 = scan, 0 = dark (IDLE)
//   Lz_En             - suppress leading zeros on digits 3..1
//   W, X, Y, Z        - nibble bits 3..0 returned by the external 4:1 mux
//   S1, S0            - registered digit select driving that mux
//   An                - active-low digit anodes, An[i] = digit i
//   Seg               - active-low segments gfedcba
//   Frame_Tick        - one-cycle pulse on the last SHOW cycle of digit 0
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Lz_En,
  input  logic       W,
  input  logic       X,
  input  logic       Y,
  input  logic       Z,
  output logic       S1,
  output logic       S0,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Frame_Tick
);

  localparam int CNT_W = $clog2(max_int(REFRESH_DIV, DEAD_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       SEL_TOP   = 2'd3;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       sel_q,     sel_d;
  logic [3:0]       nib_q,     nib_d;
  logic             blank_q,   blank_d;
  logic             seen_nz_q, seen_nz_d;

  logic [3:0] nib_in;
  logic [6:0] dec_seg;
  logic       dead_last;
  logic       show_last;

  assign nib_in    = {W, X, Y, Z};
  assign dead_last = (cnt_q == DEAD_LAST);
  assign show_last = (cnt_q == SHOW_LAST);

  ssd_hex_decode u_hex_decode (
    .nib (nib_q),
    .seg (dec_seg)
  );

  // Next-state logic. Every state change clears the counter; within a state
  // the counter stops at that state's last count, so it never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    nib_d     = nib_q;
    blank_d   = blank_q;
    seen_nz_d = seen_nz_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        sel_d = SEL_TOP;
        if (Enable) begin
          // New frame starts at digit 3 with no non-zero digit seen yet.
          state_d   = DEAD;
          seen_nz_d = 1'b0;
        end
      end

      DEAD: begin
        if (!Enable) begin
          state_d   = IDLE;
          cnt_d     = '0;
          sel_d     = SEL_TOP;
          seen_nz_d = 1'b0;
        end else if (dead_last) begin
          // The select has been stable for the whole dead interval, so the
          // external mux output has settled; capture it with Lz_En.
          state_d   = SHOW;
          cnt_d     = '0;
          nib_d     = nib_in;
          blank_d   = Lz_En && !seen_nz_q && (nib_in == 4'd0) && (sel_q != 2'd0);
          seen_nz_d = seen_nz_q || (nib_in != 4'd0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHOW: begin
        if (!Enable) begin
          state_d   = IDLE;
          cnt_d     = '0;
          sel_d     = SEL_TOP;
          seen_nz_d = 1'b0;
        end else if (show_last) begin
          // Move to the next lower digit; 0 wraps to 3, which opens a new
          // frame and restarts leading-zero tracking.
          state_d = DEAD;
          cnt_d   = '0;
          sel_d   = 2'(sel_q - 2'd1);
          if (sel_q == 2'd0) begin
            seen_nz_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        sel_d     = SEL_TOP;
        seen_nz_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= SEL_TOP;
      nib_q     <= 4'd0;
      blank_q   <= 1'b0;
      seen_nz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      nib_q     <= nib_d;
      blank_q   <= blank_d;
      seen_nz_q <= seen_nz_d;
    end
  end

  // Outputs decode directly from registered state, so anodes only light
  // while in SHOW and stay dark across the whole dead interval.
  always_comb begin
    S1         = sel_q[1];
    S0         = sel_q[0];
    An         = AN_OFF;
    Seg        = SEG_OFF;
    Frame_Tick = 1'b0;
    if (state_q == SHOW) begin
      An         = ~(4'b0001 << sel_q);
      Seg        = blank_q ? SEG_OFF : dec_seg;
      Frame_Tick = (sel_q == 2'd0) && show_last;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with REFRESH_DIV = 4, DEAD_CYCLES = 2.
// A frame-position model predicts select, anodes, segments and frame tick each cycle.
// The bench drives a behavioural 4:1 mux from a 16-bit value using the DUT's S1/S0.
module tb_ssd_scan_ctrl;

  localparam int RD    = 4;
  localparam int DC    = 2;
  localparam int P     = RD + DC;     // digit period
  localparam int FRAME = 4 * P;

  logic        Clock;
  logic        Resetn;
  logic        Enable;
  logic        Lz_En;
  logic        W, X, Y, Z;
  logic        S1, S0;
  logic [3:0]  An;
  logic [6:0]  Seg;
  logic        Frame_Tick;

  logic [15:0] value;
  logic [3:0]  mux_nib;

  int compared   = 0;
  int mismatched = 0;
  int tick_seen  = 0;

  // Reference model: position within the frame since DEAD entry of digit 3.
  bit         m_active;
  int         m_pos;
  logic [3:0] m_nib;
  bit         m_blank;
  bit         m_seen;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Enable     (Enable),
    .Lz_En      (Lz_En),
    .W          (W),
    .X          (X),
    .Y          (Y),
    .Z          (Z),
    .S1         (S1),
    .S0         (S0),
    .An         (An),
    .Seg        (Seg),
    .Frame_Tick (Frame_Tick)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always_comb begin
    mux_nib = value[int'({S1, S0}) * 4 +: 4];
  end
  assign {W, X, Y, Z} = mux_nib;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cur_digit();
    return 3 - m_pos / P;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int d;
    if (!Resetn) begin
      m_active = 0; m_pos = 0; m_seen = 0;
    end else if (!m_active) begin
      if (Enable) begin
        m_active = 1; m_pos = 0; m_seen = 0;
      end
    end else if (!Enable) begin
      m_active = 0; m_pos = 0; m_seen = 0;
    end else begin
      d = cur_digit();
      if (m_pos % P == DC - 1) begin
        m_nib   = value[d*4 +: 4];
        m_blank = Lz_En && !m_seen && (m_nib == 4'd0) && (d != 0);
        if (m_nib != 4'd0) m_seen = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) m_seen = 0;
    end
  endtask

  task automatic check_all();
    logic [1:0] e_sel;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_tick;
    int d;
    int ph;
    e_sel = 2'd3; e_an = 4'hF; e_seg = 7'h7F; e_tick = 1'b0;
    if (m_active) begin
      d     = cur_digit();
      ph    = m_pos % P;
      e_sel = 2'(d);
      if (ph >= DC) begin
        e_an   = 4'(~(4'b0001 << d));
        e_seg  = m_blank ? 7'h7F : seg_tab[m_nib];
        e_tick = (d == 0) && (ph == P - 1);
      end
    end
    chk("sel",  8'({S1, S0}),   8'(e_sel));
    chk("an",   8'(An),         8'(e_an));
    chk("seg",  8'(Seg),        8'(e_seg));
    chk("tick", 8'(Frame_Tick), 8'(e_tick));
    if (Frame_Tick) tick_seen++;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int guard;
    m_active = 0; m_pos = 0; m_nib = 4'd0; m_blank = 0; m_seen = 0;
    Resetn = 1'b0; Enable = 1'b1; Lz_En = 1'b0; value = 16'h1234;

    // 1: reset with Enable high, then full frames of 0x1234.
    run(3);
    chk("rst_sel", 8'({S1, S0}), 8'd3);
    chk("rst_an",  8'(An),       8'hF);
    chk("rst_seg", 8'(Seg),      8'h7F);
    Resetn = 1'b1;
    tick_seen = 0;
    run(2);
    chk("dead_an", 8'(An), 8'hF);
    cyc();
    chk("d3_an",  8'(An),  8'b0111);
    chk("d3_seg", 8'(Seg), 8'h79);
    run(45);
    chk("ticks_48", 8'(tick_seen), 8'd2);

    // 2: letters, no suppression; value changes mid-frame exercise scenario 6.
    value = 16'hABCF;
    run(2 * FRAME);

    // 3: leading-zero suppression.
    Lz_En = 1'b1;
    value = 16'h0050;
    run(2 * FRAME);
    value = 16'h0000;
    run(2 * FRAME);
    Lz_En = 1'b0;
    value = 16'h1234;
    run(FRAME);

    // 4: drop Enable mid-SHOW of digit 2, then re-enable.
    guard = 0;
    while (!(m_active && cur_digit() == 2 && m_pos % P == DC + 1) && guard < 40) begin
      cyc();
      guard++;
    end
    chk("reach_d2", 8'(guard < 40), 8'd1);
    Enable = 1'b0;
    cyc();
    chk("dis_an",  8'(An),  8'hF);
    chk("dis_seg", 8'(Seg), 8'h7F);
    run(3);
    Enable = 1'b1;
    run(FRAME + 4);

    // 5: one-cycle reset pulse mid-SHOW of digit 1 with suppression active.
    Lz_En = 1'b1;
    value = 16'h0705;
    guard = 0;
    while (!(m_active && cur_digit() == 1 && m_pos % P == DC + 1) && guard < 40) begin
      cyc();
      guard++;
    end
    chk("reach_d1", 8'(guard < 40), 8'd1);
    Resetn = 1'b0;
    cyc();
    chk("pulse_sel", 8'({S1, S0}), 8'd3);
    chk("pulse_an",  8'(An),       8'hF);
    chk("pulse_seg", 8'(Seg),      8'h7F);
    Resetn = 1'b1;
    run(2 * FRAME);

    // 6: randomized traffic with occasional disable and reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      if ($urandom_range(0, 9) == 0) value = {4'd0, 4'd0, 4'($urandom), 4'($urandom)};
      if ($urandom_range(0, 31) == 0) Lz_En = 1'($urandom);
      Enable = ($urandom_range(0, 99) != 0);
      Resetn = ($urandom_range(0, 199) != 0);
      cyc();
    end
    Resetn = 1'b1;
    Enable = 1'b1;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
